// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction ROM port, branch redirect and the decode handshake.
// The master modport is the fetch sequencer's view; slave is the memory/decode/execute side.
interface fetch_sequencer_if #(
    parameter int WIDTH = 24,
    parameter int AW    = 8
);
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rd;
    logic             br_taken;
    logic [AW-1:0]    br_target;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [AW-1:0]    out_pc;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  br_taken,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output br_taken,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational ROM and buffers {pc, instr} in a 2-entry FIFO.
// Define FETCH_HALT_EN to stop fetching after an instruction whose opcode equals HALT_OP.
module fetch_sequencer #(
    parameter int              WIDTH    = 24,
    parameter int              AMOUNT   = 256,
    parameter int              AW       = $clog2(AMOUNT),
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [4:0]      HALT_OP  = 5'b11111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    fetch_sequencer_if.master   bus,
    output logic                busy,
    output logic                halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    state_t         state, state_next;
    logic [AW-1:0]  pc, pc_next, pc_inc;
    logic [1:0]     count, count_next;
    logic           rd_ptr, rd_ptr_next;
    logic           wr_ptr, wr_ptr_next;

    logic [AW-1:0]    fifo_pc    [2];
    logic [WIDTH-1:0] fifo_instr [2];

    logic pop, push, redirect, restart, halt_hit;

    // Explicit wrap so non-power-of-two ROM depths still roll over to address 0.
    assign pc_inc = (pc == AW'(AMOUNT - 1)) ? '0 : pc + AW'(1);

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.out_pc    = fifo_pc[rd_ptr];
    assign bus.imem_addr = WIDTH'(pc);

    assign pop      = bus.out_valid && bus.out_ready;
    assign restart  = start && (state != FETCH);
    assign redirect = (state == FETCH) && bus.br_taken;
    // A full buffer may still accept when its head leaves in the same cycle.
    assign push     = (state == FETCH) && !bus.br_taken && ((count != 2'd2) || pop);
    assign halt_hit = HALT_EN && push && (bus.imem_rd[WIDTH-1 -: 5] == HALT_OP);

    assign busy   = (state == FETCH) || (count != 2'd0);
    assign halted = HALT_EN && (state == HALT);

    // State, PC and FIFO bookkeeping; restart beats redirect, which beats push/pop.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        count_next  = count;
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        if (restart) begin
            state_next  = FETCH;
            pc_next     = RESET_PC;
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else if (redirect) begin
            pc_next     = bus.br_target;
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            if (push) begin
                pc_next     = pc_inc;
                wr_ptr_next = ~wr_ptr;
                if (halt_hit) begin
                    state_next = HALT;
                end
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            count  <= count_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= bus.imem_rd;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {pc, instr} pairs are queued as stimulus is applied
// and compared on every decode handshake; a second instance covers a non-zero RESET_PC across the wrap.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0]  pc;
        logic [23:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start2;
    logic busy, halted;
    logic busy2, halted2;

    logic [23:0] rom [256];
    exp_t        q [$];
    int          tests  = 0;
    int          failed = 0;

    fetch_sequencer_if #(.WIDTH(24), .AW(8)) bus ();
    fetch_sequencer_if #(.WIDTH(24), .AW(8)) bus2 ();

    fetch_sequencer #(
        .WIDTH(24), .AMOUNT(256), .AW(8), .RESET_PC(8'h00), .HALT_OP(5'b11111)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .halted(halted)
    );

    fetch_sequencer #(
        .WIDTH(24), .AMOUNT(256), .AW(8), .RESET_PC(8'hFE), .HALT_OP(5'b11111)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2), .busy(busy2), .halted(halted2)
    );

    always #5 clk = ~clk;

    assign bus.imem_rd   = rom[bus.imem_addr[7:0]];
    assign bus2.imem_rd  = rom[bus2.imem_addr[7:0]];
    assign bus2.br_taken  = 1'b0;
    assign bus2.br_target = 8'h00;
    assign bus2.out_ready = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [7:0] tgt, input logic rdy);
        start         = st;
        bus.br_taken  = br;
        bus.br_target = tgt;
        bus.out_ready = rdy;
    endtask

    task automatic pushExpect(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            p = 8'(first + i);
            q.push_back({p, rom[p]});
        end
    endtask

    // Samples mid-cycle; a visible handshake retires the oldest expected entry.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            checkOutput("head_pc", 32'(bus.out_pc), 32'(e.pc));
            checkOutput("head_instr", 32'(bus.out_instr), 32'(e.instr));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            bus.out_ready = 1'b1;
            sample();
            checkOutput("no_bubble", 32'(bus.out_valid), 32'd1);
            advance();
            n++;
        end
        bus.out_ready = 1'b0;
        if (q.size() != 0) begin
            checkOutput("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'(i);
        rst    = 1'b1;
        start2 = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset values
        advance();
        advance();
        sample();
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_addr", 32'(bus.imem_addr), 32'h0);
        checkOutput("rst_instr", 32'(bus.out_instr), 32'h0);
        checkOutput("rst_pc", 32'(bus.out_pc), 32'h0);
        checkOutput("rst_addr2", 32'(bus2.imem_addr), 32'hFE);
        advance();
        rst = 1'b0;

        // Start and streaming throughput
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sample();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("start_lat_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("start_lat_addr", 32'(bus.imem_addr), 32'h0);
        checkOutput("start_busy", 32'(busy), 32'd1);
        advance();
        pushExpect(0, 8);
        drain(40);

        // Stall: buffer fills, head and pc hold
        for (int i = 0; i < 2; i++) begin
            sample();
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_pc", 32'(bus.out_pc), 32'd8);
            checkOutput("stall_instr", 32'(bus.out_instr), 32'd8);
            checkOutput("stall_addr", 32'(bus.imem_addr), 32'd10);
            advance();
        end
        pushExpect(8, 4);
        drain(40);

        // Redirect with a full buffer and no pop
        sample();
        advance();
        applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
        sample();
        checkOutput("pre_br_pc", 32'(bus.out_pc), 32'd12);
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("br_bubble", 32'(bus.out_valid), 32'd0);
        checkOutput("br_addr", 32'(bus.imem_addr), 32'h40);
        advance();
        pushExpect(8'h40, 4);
        drain(40);

        // Redirect coinciding with a pop, then stream across the PC wrap
        pushExpect(8'h44, 1);
        applyStimulus(1'b0, 1'b1, 8'hFE, 1'b1);
        sample();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("br_pop_done", 32'(q.size()), 32'd0);
        sample();
        checkOutput("br2_bubble", 32'(bus.out_valid), 32'd0);
        checkOutput("br2_addr", 32'(bus.imem_addr), 32'hFE);
        advance();
        pushExpect(8'hFE, 4);
        drain(40);

        // Halt opcode at pc 3
        rom[3] = {5'b11111, 19'h0};
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        sample();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("br3_addr", 32'(bus.imem_addr), 32'h0);
        advance();
`ifdef FETCH_HALT_EN
        pushExpect(0, 4);
        drain(40);
        sample();
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("halt_busy", 32'(busy), 32'd0);
        checkOutput("halt_addr", 32'(bus.imem_addr), 32'd4);
        advance();
        applyStimulus(1'b0, 1'b1, 8'h20, 1'b0);
        sample();
        advance();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("halt_br_ignored", 32'(bus.imem_addr), 32'd4);
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("restart_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("restart_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("restart_halted", 32'(halted), 32'd0);
        advance();
        pushExpect(0, 4);
        drain(40);
        sample();
        checkOutput("halt2_halted", 32'(halted), 32'd1);
        advance();
`else
        pushExpect(0, 6);
        drain(40);
        sample();
        checkOutput("nohalt_halted", 32'(halted), 32'd0);
        checkOutput("nohalt_busy", 32'(busy), 32'd1);
        advance();
`endif
        rom[3] = 24'd3;

        // Start pulse: restarts from HALT, ignored while fetching
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sample();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            advance();
        end
        sample();
        checkOutput("full_valid", 32'(bus.out_valid), 32'd1);
`ifdef FETCH_HALT_EN
        checkOutput("full_addr", 32'(bus.imem_addr), 32'd2);
        checkOutput("full_pc", 32'(bus.out_pc), 32'd0);
`else
        checkOutput("start_ignored_addr", 32'(bus.imem_addr), 32'd8);
        checkOutput("start_ignored_pc", 32'(bus.out_pc), 32'd6);
`endif
        advance();

        // Reset with a full buffer, then a branch in IDLE
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        sample();
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("mid_rst_halted", 32'(halted), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
        sample();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        checkOutput("idle_br_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("idle_br_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("idle_br_busy", 32'(busy), 32'd0);
        advance();

        // Non-zero RESET_PC instance wraps from 0xFF to 0x00 without a bubble
        start2 = 1'b1;
        @(negedge clk);
        advance();
        start2 = 1'b0;
        @(negedge clk);
        checkOutput("rpc_lat_valid", 32'(bus2.out_valid), 32'd0);
        checkOutput("rpc_lat_addr", 32'(bus2.imem_addr), 32'hFE);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] p;
            p = 8'(8'hFE + i);
            advance();
            @(negedge clk);
            checkOutput("rpc_valid", 32'(bus2.out_valid), 32'd1);
            checkOutput("rpc_pc", 32'(bus2.out_pc), 32'(p));
            checkOutput("rpc_instr", 32'(bus2.out_instr), 32'(rom[p]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
